// File: rtl/patch_ring_pkg.sv
// Shared definitions for the rotating patch memory: logical slot names,
// controller states and the logical-to-physical slot mapping.
package patch_ring_pkg;

  localparam int unsigned SLOT_PREV = 0;
  localparam int unsigned SLOT_CURR = 1;
  localparam int unsigned SLOT_NEXT = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } ring_state_e;

  // base < num_slot and slot < num_slot, so one conditional subtract replaces the modulo.
  function automatic int unsigned phys_slot(input int unsigned base,
                                            input int unsigned slot,
                                            input int unsigned num_slot);
    int unsigned sum;
    sum = base + slot;
    if (sum >= num_slot) sum = sum - num_slot;
    return sum;
  endfunction

endpackage

// File: rtl/patch_ram.sv
// Flat patch storage: one write port and two synchronous read ports.
// A read of a word being written in the same cycle returns the old contents.
module patch_ram #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned DEPTH  = 48,
  parameter int unsigned AW     = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a_q,
  output logic [DATA_W-1:0] rdata_b_q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) begin
      rdata_a_q <= mem[raddr_a];
      rdata_b_q <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/patch_ring_mem.sv
// Ring of NUM_SLOT solver patches addressed through a rotating base pointer,
// with dual prev/curr read, zero-fill sequencer and registered read-valid.
module patch_ring_mem
  import patch_ring_pkg::*;
#(
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned PATCH_SIZE = 16,
  parameter int unsigned NUM_SLOT   = 3,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned SLOT_W     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init_req,
  output logic                     init_busy,
  input  logic                     rotate,
  input  logic                     wr_en,
  input  logic [SLOT_W-1:0]        wr_slot,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_prev,
  output logic signed [DATA_W-1:0] rd_curr,
  output logic                     rd_valid
);

  localparam int unsigned DEPTH  = NUM_SLOT * PATCH_SIZE;
  localparam int unsigned RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ring_state_e       state_q, state_d;
  logic [SLOT_W-1:0] base_q, base_d;
  logic [RAM_AW-1:0] clr_cnt_q, clr_cnt_d;
  logic              rd_valid_q, rd_valid_d;
  // Forces the read outputs to zero (after reset or an out-of-range read).
  logic              rd_zero_q, rd_zero_d;

  logic              ram_we, ram_re;
  logic [RAM_AW-1:0] ram_waddr, ram_prev_addr, ram_curr_addr;
  logic [DATA_W-1:0] ram_wdata, ram_prev, ram_curr;

  logic              wr_ok, rd_in_range;
  int unsigned       wr_word, prev_word, curr_word;

  always_comb begin
    wr_ok       = wr_en && (32'(wr_addr) < PATCH_SIZE) && (32'(wr_slot) < NUM_SLOT);
    rd_in_range = 32'(rd_addr) < PATCH_SIZE;
    wr_word     = phys_slot(32'(base_q), 32'(wr_slot), NUM_SLOT) * PATCH_SIZE + 32'(wr_addr);
    prev_word   = phys_slot(32'(base_q), SLOT_PREV, NUM_SLOT) * PATCH_SIZE + 32'(rd_addr);
    curr_word   = phys_slot(32'(base_q), SLOT_CURR, NUM_SLOT) * PATCH_SIZE + 32'(rd_addr);

    state_d       = state_q;
    base_d        = base_q;
    clr_cnt_d     = clr_cnt_q;
    rd_valid_d    = 1'b0;
    rd_zero_d     = rd_zero_q;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_waddr     = RAM_AW'(wr_word);
    ram_wdata     = wr_data;
    ram_prev_addr = RAM_AW'(prev_word);
    ram_curr_addr = RAM_AW'(curr_word);

    case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d   = ST_CLEAR;
          base_d    = '0;
          clr_cnt_d = '0;
        end else begin
          ram_we = wr_ok;
          if (rotate) base_d = (base_q == SLOT_W'(NUM_SLOT - 1)) ? '0 : base_q + 1'b1;
        end
        if (rd_en) begin
          rd_valid_d = 1'b1;
          rd_zero_d  = !rd_in_range;
          ram_re     = rd_in_range;
        end
      end
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == RAM_AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A reset cycle must not disturb RAM contents.
    if (reset) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      clr_cnt_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  patch_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk      (clk),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .re       (ram_re),
    .raddr_a  (ram_prev_addr),
    .raddr_b  (ram_curr_addr),
    .rdata_a_q(ram_prev),
    .rdata_b_q(ram_curr)
  );

  assign init_busy = (state_q == ST_CLEAR);
  assign rd_valid  = rd_valid_q;
  assign rd_prev   = rd_zero_q ? '0 : ram_prev;
  assign rd_curr   = rd_zero_q ? '0 : ram_curr;

endmodule

// File: tb/tb_patch_ring_mem.sv
// Randomised and directed bench for patch_ring_mem: instance A uses the default
// 3x16 geometry, instance B a 4x12 geometry for range-checking cases.
module tb_patch_ring_mem;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: DATA_W 18, PATCH_SIZE 16, NUM_SLOT 3
  logic        a_init_req, a_init_busy, a_rotate, a_wr_en, a_rd_en, a_rd_valid;
  logic [1:0]  a_wr_slot;
  logic [3:0]  a_wr_addr, a_rd_addr;
  logic signed [17:0] a_wr_data, a_rd_prev, a_rd_curr;

  // Instance B: PATCH_SIZE 12, NUM_SLOT 4
  logic        b_init_req, b_init_busy, b_rotate, b_wr_en, b_rd_en, b_rd_valid;
  logic [2:0]  b_wr_slot;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic signed [17:0] b_wr_data, b_rd_prev, b_rd_curr;

  patch_ring_mem dut_a (
    .clk(clk), .reset(reset), .init_req(a_init_req), .init_busy(a_init_busy),
    .rotate(a_rotate), .wr_en(a_wr_en), .wr_slot(a_wr_slot), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_prev(a_rd_prev), .rd_curr(a_rd_curr), .rd_valid(a_rd_valid)
  );

  patch_ring_mem #(.DATA_W(18), .PATCH_SIZE(12), .NUM_SLOT(4), .ADDR_W(4), .SLOT_W(3)) dut_b (
    .clk(clk), .reset(reset), .init_req(b_init_req), .init_busy(b_init_busy),
    .rotate(b_rotate), .wr_en(b_wr_en), .wr_slot(b_wr_slot), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_prev(b_rd_prev), .rd_curr(b_rd_curr), .rd_valid(b_rd_valid)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model for A: physical patches plus a queue of physical ids in
  // logical order (index 0 = PREV, 1 = CURR, 2 = NEXT); a time step pops PREV
  // off the front and appends it as the new last slot.
  logic [17:0] mem_m [3][16];
  int          q[$];
  logic [17:0] exp_prev, exp_curr;
  logic        exp_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_init_req = 0; a_rotate = 0; a_wr_en = 0; a_rd_en = 0;
    a_wr_slot = 0; a_wr_addr = 0; a_wr_data = 0; a_rd_addr = 0;
  endtask

  task automatic b_idle();
    b_init_req = 0; b_rotate = 0; b_wr_en = 0; b_rd_en = 0;
    b_wr_slot = 0; b_wr_addr = 0; b_wr_data = 0; b_rd_addr = 0;
  endtask

  task automatic model_identity();
    q.delete();
    for (int s = 0; s < 3; s++) q.push_back(s);
  endtask

  // One IDLE cycle on A; updates the model and the expected read result.
  task automatic drive(input bit w, input int slot, input int addr, input logic [17:0] data,
                       input bit rot, input bit rd, input int raddr);
    a_wr_en = w; a_wr_slot = 2'(slot); a_wr_addr = 4'(addr); a_wr_data = data;
    a_rotate = rot; a_rd_en = rd; a_rd_addr = 4'(raddr);
    tick();
    exp_valid = rd;
    if (rd) begin
      exp_prev = mem_m[q[0]][raddr];
      exp_curr = mem_m[q[1]][raddr];
    end
    if (w && slot < 3) mem_m[q[slot]][addr] = data;
    if (rot) q.push_back(q.pop_front());
    a_idle();
  endtask

  task automatic test_reset();
    reset = 1; a_idle(); b_idle();
    repeat (3) tick();
    reset = 0;
    vectors += 4;
    if (a_init_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", a_init_busy); end
    if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", a_rd_valid); end
    if (a_rd_prev !== 18'd0) begin errors++; $display("FAIL reset_prev got=%h want=0", a_rd_prev); end
    if (a_rd_curr !== 18'd0) begin errors++; $display("FAIL reset_curr got=%h want=0", a_rd_curr); end
    $display("reset: busy=%b valid=%b prev=%h curr=%h", a_init_busy, a_rd_valid, a_rd_prev, a_rd_curr);
  endtask

  // Zero-fill with stray requests during CLEAR; they must have no effect.
  task automatic test_init_clear();
    int n;
    a_init_req = 1; a_rotate = 1; a_wr_en = 1; a_wr_slot = 0; a_wr_addr = 0; a_wr_data = 18'd5;
    tick();
    a_idle();
    n = 0;
    while (a_init_busy === 1'b1 && n < 200) begin
      vectors++;
      if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL clear_valid cyc=%0d got=%b want=0", n, a_rd_valid); end
      a_idle();
      if (n == 10) begin
        a_wr_en = 1; a_wr_slot = 0; a_wr_addr = 0; a_wr_data = 18'd123;
        a_rotate = 1; a_rd_en = 1; a_rd_addr = 0;
      end
      if (n == 11) a_init_req = 1;
      tick();
      n++;
    end
    a_idle();
    vectors++;
    if (n != 48) begin errors++; $display("FAIL init_busy_len got=%0d want=48", n); end
    $display("init: busy cycles=%0d", n);
    model_identity();
    for (int p = 0; p < 3; p++) for (int w = 0; w < 16; w++) mem_m[p][w] = '0;
    exp_prev = '0; exp_curr = '0;
    for (int ad = 0; ad < 16; ad++) begin
      drive(0, 0, 0, 0, 0, 1, ad);
      vectors += 3;
      if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL init_rd_valid addr=%0d got=%b want=1", ad, a_rd_valid); end
      if (a_rd_prev !== exp_prev) begin errors++; $display("FAIL init_prev addr=%0d got=%h want=%h", ad, a_rd_prev, exp_prev); end
      if (a_rd_curr !== exp_curr) begin errors++; $display("FAIL init_curr addr=%0d got=%h want=%h", ad, a_rd_curr, exp_curr); end
    end
    $display("init: all words read back, prev=%h curr=%h", a_rd_prev, a_rd_curr);
  endtask

  task automatic test_rotate();
    drive(1, 2, 5, 18'h3FFFD, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 5);
    vectors += 2;
    if (a_rd_curr !== 18'h3FFFD) begin errors++; $display("FAIL rot1_curr got=%h want=3fffd", a_rd_curr); end
    if (a_rd_prev !== 18'd0) begin errors++; $display("FAIL rot1_prev got=%h want=0", a_rd_prev); end
    $display("rotate1: prev=%h curr=%h", a_rd_prev, a_rd_curr);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 5);
    vectors += 2;
    if (a_rd_prev !== 18'h3FFFD) begin errors++; $display("FAIL rot2_prev got=%h want=3fffd", a_rd_prev); end
    if (a_rd_curr !== exp_curr) begin errors++; $display("FAIL rot2_curr got=%h want=%h", a_rd_curr, exp_curr); end
    $display("rotate2: prev=%h curr=%h", a_rd_prev, a_rd_curr);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 2, 5, 18'd7, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 5);
    vectors += 1;
    if (a_rd_curr !== 18'd7) begin errors++; $display("FAIL rot4_curr got=%h want=7", a_rd_curr); end
    $display("rotate4: prev=%h curr=%h", a_rd_prev, a_rd_curr);
  endtask

  task automatic test_same_cycle();
    drive(1, 2, 2, 18'd100, 1, 1, 2);
    vectors += 3;
    if (a_rd_valid !== 1'b1) begin errors++; $display("FAIL same_valid got=%b want=1", a_rd_valid); end
    if (a_rd_prev !== exp_prev) begin errors++; $display("FAIL same_prev got=%h want=%h", a_rd_prev, exp_prev); end
    if (a_rd_curr !== exp_curr) begin errors++; $display("FAIL same_curr got=%h want=%h", a_rd_curr, exp_curr); end
    $display("same-cycle: prev=%h curr=%h", a_rd_prev, a_rd_curr);
    drive(0, 0, 0, 0, 0, 1, 2);
    vectors += 1;
    if (a_rd_curr !== 18'd100) begin errors++; $display("FAIL same_next_curr got=%h want=64", a_rd_curr); end
    $display("same-cycle follow-up: curr=%h", a_rd_curr);
  endtask

  task automatic test_read_first();
    drive(1, 1, 9, 18'd1, 0, 0, 0);
    drive(1, 1, 9, 18'd2, 0, 1, 9);
    vectors += 1;
    if (a_rd_curr !== 18'd1) begin errors++; $display("FAIL rfirst_curr got=%h want=1", a_rd_curr); end
    drive(0, 0, 0, 0, 0, 1, 9);
    vectors += 1;
    if (a_rd_curr !== 18'd2) begin errors++; $display("FAIL rfirst_after got=%h want=2", a_rd_curr); end
    $display("read-first: after curr=%h", a_rd_curr);
  endtask

  task automatic test_random();
    int slot, addr, raddr;
    bit w, rot, rd;
    logic [17:0] data;
    for (int i = 0; i < 400; i++) begin
      w = 1'($urandom_range(0, 1)); slot = $urandom_range(0, 3); addr = $urandom_range(0, 7);
      data = 18'($urandom); rot = ($urandom_range(0, 3) == 0); rd = 1'($urandom_range(0, 1));
      raddr = $urandom_range(0, 7);
      drive(w, slot, addr, data, rot, rd, raddr);
      vectors += 3;
      if (a_rd_valid !== exp_valid) begin errors++; $display("FAIL rand_valid i=%0d got=%b want=%b", i, a_rd_valid, exp_valid); end
      if (a_rd_prev !== exp_prev) begin errors++; $display("FAIL rand_prev i=%0d got=%h want=%h", i, a_rd_prev, exp_prev); end
      if (a_rd_curr !== exp_curr) begin errors++; $display("FAIL rand_curr i=%0d got=%h want=%h", i, a_rd_curr, exp_curr); end
      $display("rand %0d: w=%0d s=%0d a=%0d rot=%0d rd=%0d ra=%0d -> v=%b p=%h c=%h", i, w, slot, addr, rot, rd, raddr, a_rd_valid, a_rd_prev, a_rd_curr);
    end
  endtask

  task automatic test_reset_mid_clear();
    int s1;
    s1 = 0;
    for (int s = 0; s < 3; s++) if (q[s] == 1) s1 = s;
    drive(1, s1, 14, 18'd12345, 0, 0, 0);
    drive(1, s1, 2, 18'h2AAAA, 0, 0, 0);
    a_init_req = 1;
    tick();
    a_idle();
    repeat (20) tick();
    reset = 1;
    tick();
    reset = 0;
    vectors += 4;
    if (a_init_busy !== 1'b0) begin errors++; $display("FAIL midclr_busy got=%b want=0", a_init_busy); end
    if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL midclr_valid got=%b want=0", a_rd_valid); end
    if (a_rd_prev !== 18'd0) begin errors++; $display("FAIL midclr_prev0 got=%h want=0", a_rd_prev); end
    if (a_rd_curr !== 18'd0) begin errors++; $display("FAIL midclr_curr0 got=%h want=0", a_rd_curr); end
    $display("mid-clear reset: busy=%b", a_init_busy);
    for (int wd = 0; wd < 20; wd++) mem_m[wd / 16][wd % 16] = '0;
    model_identity();
    for (int ad = 0; ad < 16; ad++) begin
      drive(0, 0, 0, 0, 0, 1, ad);
      vectors += 2;
      if (a_rd_prev !== exp_prev) begin errors++; $display("FAIL midclr_prev addr=%0d got=%h want=%h", ad, a_rd_prev, exp_prev); end
      if (a_rd_curr !== exp_curr) begin errors++; $display("FAIL midclr_curr addr=%0d got=%h want=%h", ad, a_rd_curr, exp_curr); end
      $display("mid-clear read addr %0d: prev=%h curr=%h", ad, a_rd_prev, a_rd_curr);
    end
    vectors++;
    if (a_rd_curr !== 18'd0) begin errors++; $display("FAIL midclr_word31 got=%h want=0", a_rd_curr); end
  endtask

  task automatic b_read(input int ad);
    b_rd_en = 1; b_rd_addr = 4'(ad);
    tick();
    b_rd_en = 0;
  endtask

  task automatic test_out_of_range();
    int n;
    b_init_req = 1;
    tick();
    b_init_req = 0;
    n = 0;
    while (b_init_busy === 1'b1 && n < 200) begin tick(); n++; end
    vectors++;
    if (n != 48) begin errors++; $display("FAIL b_init_len got=%0d want=48", n); end
    b_wr_en = 1; b_wr_slot = 0; b_wr_addr = 3; b_wr_data = 18'd55; tick();
    b_wr_slot = 0; b_wr_addr = 13; b_wr_data = 18'd77; tick();
    b_wr_slot = 5; b_wr_addr = 3; b_wr_data = 18'd99; tick();
    b_idle();
    b_read(3);
    vectors += 2;
    if (b_rd_prev !== 18'd55) begin errors++; $display("FAIL oob_prev3 got=%h want=37", b_rd_prev); end
    if (b_rd_curr !== 18'd0) begin errors++; $display("FAIL oob_slot5 got=%h want=0", b_rd_curr); end
    b_read(1);
    vectors++;
    if (b_rd_curr !== 18'd0) begin errors++; $display("FAIL oob_addr13 got=%h want=0", b_rd_curr); end
    b_read(3);
    b_read(13);
    vectors += 3;
    if (b_rd_valid !== 1'b1) begin errors++; $display("FAIL oob_rd_valid got=%b want=1", b_rd_valid); end
    if (b_rd_prev !== 18'd0) begin errors++; $display("FAIL oob_rd_prev got=%h want=0", b_rd_prev); end
    if (b_rd_curr !== 18'd0) begin errors++; $display("FAIL oob_rd_curr got=%h want=0", b_rd_curr); end
    $display("oob read: valid=%b prev=%h curr=%h", b_rd_valid, b_rd_prev, b_rd_curr);
    b_rotate = 1; tick(); b_rotate = 0;
    b_read(3);
    vectors++;
    if (b_rd_prev !== 18'd0) begin errors++; $display("FAIL b_rot1_prev got=%h want=0", b_rd_prev); end
    b_rotate = 1; repeat (3) tick(); b_rotate = 0;
    b_read(3);
    vectors++;
    if (b_rd_prev !== 18'd55) begin errors++; $display("FAIL b_rot4_prev got=%h want=37", b_rd_prev); end
    $display("four rotates: prev=%h", b_rd_prev);
  endtask

  initial begin
    test_reset();
    test_init_clear();
    test_rotate();
    test_same_cycle();
    test_read_first();
    test_random();
    test_reset_mid_clear();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/patch_ring_mem.md
Name: patch_ring_mem

Overview:
- Parametrised successor to the single-port 3-patch node memory used by the wave-equation solver.
- Holds NUM_SLOT patches of PATCH_SIZE signed words (u_prev / u_curr / u_next time steps) as a rotating ring.
- Logical slots map to physical patches through a rotating base pointer, so a time-step advance costs one cycle and no data copy.
- Adds a dual synchronous read (prev and curr at one address), a zero-fill sequencer and a registered read-valid.

Parameters:
- DATA_W, 18, signed word width (1.17 fixed point).
- PATCH_SIZE, 16, words per patch; need not be a power of two.
- NUM_SLOT, 3, patches in ring; must be >= 3.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= PATCH_SIZE.
- SLOT_W, 2, slot-index width; must satisfy 2**SLOT_W >= NUM_SLOT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- init_req  in  1  pulse: start zero-fill of all patches.
- init_busy  out  1  high while zero-fill runs.
- rotate  in  1  pulse: advance one time step.
- wr_en  in  1  write strobe.
- wr_slot  in  SLOT_W  logical slot (0=PREV, 1=CURR, 2=NEXT, >2 extra ring slots).
- wr_addr  in  ADDR_W  word offset in patch.
- wr_data  in  DATA_W signed  write data.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_W  word offset in patch.
- rd_prev  out  DATA_W signed  word from slot PREV.
- rd_curr  out  DATA_W signed  word from slot CURR.
- rd_valid  out  1  rd_prev/rd_curr updated this cycle.

Behaviour:
- Reset: base=0, FSM=IDLE, init_busy=0, rd_valid=0, rd_prev=0, rd_curr=0.
- Reset does not clear RAM; software issues init_req.
- Mapping: phys(slot) = (base+slot) mod NUM_SLOT, computed by compare/subtract with no divider.
- Physical word index = phys*PATCH_SIZE + addr.
- Rotate in IDLE: base = (base+1) mod NUM_SLOT.
  - Old NEXT becomes CURR; old CURR becomes PREV; old PREV becomes the slot NUM_SLOT-1 (NEXT when NUM_SLOT=3).
- Write: single cycle, in IDLE only.
  - Dropped if wr_addr >= PATCH_SIZE or wr_slot >= NUM_SLOT.
- Read: latency 1.
  - rd_en at cycle t gives rd_prev/rd_curr and rd_valid=1 at t+1.
  - Outputs hold their last value when rd_valid=0.
  - If rd_addr >= PATCH_SIZE, both outputs read 0 with rd_valid=1.
- Same-cycle events in IDLE: the write, the read and rotate all use the pre-rotation base.
- Read-during-write to the same physical word returns the old data (read-first).
- FSM:
  - IDLE -> CLEAR on init_req. base is set to 0 and the clear counter to 0.
  - CLEAR: writes 0 to word counter each cycle, counter+1.
  - CLEAR -> IDLE after word NUM_SLOT*PATCH_SIZE-1 is written. Total NUM_SLOT*PATCH_SIZE cycles with init_busy=1.
- During CLEAR: wr_en, rotate, init_req and rd_en are ignored, and rd_valid=0.
- init_req together with rotate or wr_en in IDLE: init wins, the others are ignored.
- Reset mid-CLEAR: FSM goes to IDLE at once and base=0. RAM is left partly cleared.
- Width rule: data is stored and returned bit-exact; no arithmetic on data.

Decomposition:
- Package patch_ring_pkg holds:
  - SLOT_PREV=0, SLOT_CURR=1, SLOT_NEXT=2;
  - FSM state encoding IDLE/CLEAR;
  - a function computing phys slot from base+slot mod NUM_SLOT.
- Sub-module patch_ram: one write port and two read ports, synchronous read, read-first, depth NUM_SLOT*PATCH_SIZE, width DATA_W.
- The top level holds base, the FSM, the clear counter, address mapping and valid logic.

Test Plan:
- Reset then init_req: init_busy high for exactly 48 cycles, then low. Reading every addr gives rd_prev=rd_curr=0 with rd_valid one cycle after rd_en.
- Write NEXT addr 5 = -3 (18'h3FFFD), rotate, read addr 5: rd_curr=-3, rd_prev=0. Rotate again, read: rd_prev=-3, rd_curr=0. Rotate a third time, write NEXT addr 5 = 7, rotate, read: rd_curr=7.
- Same cycle: wr_en NEXT addr 2 = 100, rotate=1, rd_en addr 2. Read returns old CURR/PREV values; a read on the next cycle gives rd_curr=100.
- Write CURR addr 9 = 1, then in one cycle write CURR addr 9 = 2 and rd_en addr 9: rd_curr=1. A read on the next cycle gives 2.
- During CLEAR, pulse wr_en, rotate and rd_en: no RAM change, base stays 0, rd_valid=0. Then assert reset at clear cycle 20: init_busy=0 on the next cycle, base=0, words 0-19 are 0 and word 30 keeps its prior value.
- Out-of-range: PATCH_SIZE=12, NUM_SLOT=4. Write addr 13 and write slot 5: no RAM change. Read addr 13: outputs 0, rd_valid=1. Four rotates return base to 0.
